// File: rtl/aemb2_wb_pkg.sv
// Shared definitions for the AEMB2 data-bus arbiter: arbiter state encodings
// and Wishbone data/byte-select widths.
package aemb2_wb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_G0   = 2'd1,
    ARB_G1   = 2'd2
  } arb_state_e;

  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

endpackage

// File: rtl/aemb2_wb_wdog.sv
// Strobe watchdog: counts cycles of an unanswered strobe and raises a
// one-cycle error pulse once the slave has ignored it for TMO cycles.
module aemb2_wb_wdog
  import aemb2_wb_pkg::*;
#(
  parameter int TMO = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic clr_i,
  output logic err_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       expire;

  // Count unanswered strobe cycles; restart on ack, idle strobe, clear or expiry.
  always_comb begin
    expire = stb_i & ~ack_i & ~clr_i & (cnt_q == 8'(TMO - 1));
    err_d  = expire;
    cnt_d  = cnt_q + 8'd1;
    if (clr_i || !stb_i || ack_i || expire) begin
      cnt_d = 8'd0;
    end
  end

  // Counter and registered error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/aemb2_dwb_arb.sv
// Two-master round-robin arbiter in front of a single-port data RAM.
// Ownership is locked for the owner's whole cyc tenure; a watchdog reports
// an error to the owner when the slave never acknowledges its strobe.
module aemb2_dwb_arb
  import aemb2_wb_pkg::*;
#(
  parameter int AW  = 13,
  parameter int TMO = 16
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic [AW-3:0]    m0_adr_i,
  input  logic [WB_DW-1:0] m0_dat_i,
  input  logic [WB_SW-1:0] m0_sel_i,
  input  logic             m0_stb_i,
  input  logic             m0_wre_i,
  input  logic             m0_cyc_i,
  output logic [WB_DW-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic [AW-3:0]    m1_adr_i,
  input  logic [WB_DW-1:0] m1_dat_i,
  input  logic [WB_SW-1:0] m1_sel_i,
  input  logic             m1_stb_i,
  input  logic             m1_wre_i,
  input  logic             m1_cyc_i,
  output logic [WB_DW-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic [AW-3:0]    s_adr_o,
  output logic [WB_DW-1:0] s_dat_o,
  output logic [WB_SW-1:0] s_sel_o,
  output logic             s_stb_o,
  output logic             s_wre_o,
  output logic             s_cyc_o,
  input  logic [WB_DW-1:0] s_dat_i,
  input  logic             s_ack_i,
  output logic [1:0]       gnt_o
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       wdog_err;

  // Next owner: ties go to the master that did not own the bus last;
  // releasing the bus always passes through one IDLE cycle.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? ARB_G0 : ARB_G1;
        end else if (m0_cyc_i) begin
          state_d = ARB_G0;
        end else if (m1_cyc_i) begin
          state_d = ARB_G1;
        end
      end
      ARB_G0: begin
        if (!m0_cyc_i) begin
          state_d = ARB_IDLE;
          last_d  = 1'b0;
        end
      end
      ARB_G1: begin
        if (!m1_cyc_i) begin
          state_d = ARB_IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbiter state and last-owner memory; reset lets m0 win the first tie.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign gnt_o   = {state_q == ARB_G1, state_q == ARB_G0};
  assign s_cyc_o = |gnt_o;

  // Slave-side mux from the owner; everything is zero while nobody owns the bus.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_stb_o = 1'b0;
    s_wre_o = 1'b0;
    if (gnt_o[0]) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_stb_o = m0_stb_i & m0_cyc_i;
      s_wre_o = m0_wre_i;
    end else if (gnt_o[1]) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_stb_o = m1_stb_i & m1_cyc_i;
      s_wre_o = m1_wre_i;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & gnt_o[0];
  assign m1_ack_o = s_ack_i & gnt_o[1];
  assign m0_err_o = wdog_err & gnt_o[0];
  assign m1_err_o = wdog_err & gnt_o[1];

  aemb2_wb_wdog #(
    .TMO(TMO)
  ) u_wdog (
    .clk_i(sys_clk_i),
    .rst_i(sys_rst_i),
    .stb_i(s_stb_o),
    .ack_i(s_ack_i),
    .clr_i(state_q == ARB_IDLE),
    .err_o(wdog_err)
  );

endmodule

// File: tb/tb_aemb2_dwb_arb.sv
// Testbench for aemb2_dwb_arb: a RAM slave with registered ack, directed
// arbitration/watchdog/reset scenarios, then randomized bus rounds checked
// against a shadow memory and a round-robin ownership model.
module tb_aemb2_dwb_arb;

  localparam int AW    = 13;
  localparam int TMO   = 16;
  localparam int DEPTH = 2048;

  logic        clk;
  logic        rst;
  logic [10:0] m0_adr, m1_adr;
  logic [31:0] m0_dat, m1_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_stb, m1_stb, m0_wre, m1_wre, m0_cyc, m1_cyc;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
  logic [10:0] s_adr_o;
  logic [31:0] s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_stb_o, s_wre_o, s_cyc_o;
  logic [31:0] sDat;
  logic        sAck;
  logic [1:0]  gnt_o;

  int          total;
  int          bad;
  int          lastOwner;
  bit          ackEnable;
  logic [31:0] shadow [DEPTH];
  logic [31:0] ram [DEPTH];

  aemb2_dwb_arb #(.AW(AW), .TMO(TMO)) u_dut (
    .sys_clk_i(clk), .sys_rst_i(rst),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_stb_i(m0_stb),
    .m0_wre_i(m0_wre), .m0_cyc_i(m0_cyc), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_stb_i(m1_stb),
    .m1_wre_i(m1_wre), .m1_cyc_i(m1_cyc), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_stb_o(s_stb_o),
    .s_wre_o(s_wre_o), .s_cyc_o(s_cyc_o), .s_dat_i(sDat), .s_ack_i(sAck),
    .gnt_o(gnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initVal(input int i);
    return 32'hA5C3_0000 ^ (32'(i) * 32'h9E37_79B1);
  endfunction

  // RAM slave: one registered ack per strobe, read data from before the write.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sAck <= 1'b0;
      sDat <= 32'd0;
      for (int i = 0; i < DEPTH; i++) ram[i] <= initVal(i);
    end else if (s_stb_o && !sAck && ackEnable) begin
      sAck <= 1'b1;
      sDat <= ram[s_adr_o];
      if (s_wre_o) begin
        for (int b = 0; b < 4; b++) begin
          if (s_sel_o[b]) ram[s_adr_o][8*b +: 8] <= s_dat_o[8*b +: 8];
        end
      end
    end else begin
      sAck <= 1'b0;
    end
  end

  task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic wre,
                               input logic [10:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (m == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_wre = wre; m0_adr = adr; m0_dat = dat; m0_sel = sel;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_wre = wre; m1_adr = adr; m1_dat = dat; m1_sel = sel;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic toNeg();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, 0, 0, '0, '0, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = initVal(i);
    lastOwner = 1;
    tick();
  endtask

  // One strobe on an already requesting master, checked against the shadow memory.
  task automatic beat(input int m, input logic wre, input logic [10:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] expRd;
    bit          got;
    expRd = shadow[adr];
    applyStimulus(m, 1, 1, wre, adr, dat, sel);
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      toNeg();
      if ((m == 0 ? m0_ack_o : m1_ack_o) === 1'b1) got = 1;
    end
    checkOutput("beat_ack", 32'(got), 32'd1);
    if (got) begin
      checkOutput("beat_other_ack", 32'(m == 0 ? m1_ack_o : m0_ack_o), 32'd0);
      if (!wre) begin
        checkOutput("beat_m0_dat", m0_dat_o, expRd);
        checkOutput("beat_m1_dat", m1_dat_o, expRd);
      end else begin
        for (int b = 0; b < 4; b++) if (sel[b]) shadow[adr][8*b +: 8] = dat[8*b +: 8];
      end
    end
    tick();
    applyStimulus(m, 1, 0, 0, adr, '0, '0);
  endtask

  task automatic burst(input int m, input int n, input bit wr, input int base);
    for (int i = 0; i < n; i++) begin
      beat(m, wr, 11'(base + i), $urandom, wr ? 4'($urandom_range(1, 15)) : 4'hF);
    end
  endtask

  // A round: requesters raise cyc together from an idle bus; the model picks the winner.
  task automatic round(input int req, input int n0, input int n1, input bit wr0, input bit wr1,
                       input int base0, input int base1);
    int first, second, nf, ns, bf, bs;
    bit wf, ws;
    if (req == 3) first = (lastOwner == 1) ? 0 : 1;
    else          first = (req == 1) ? 0 : 1;
    second = (req == 3) ? 1 - first : -1;
    nf = (first == 0) ? n0 : n1;       ns = (first == 0) ? n1 : n0;
    wf = (first == 0) ? wr0 : wr1;     ws = (first == 0) ? wr1 : wr0;
    bf = (first == 0) ? base0 : base1; bs = (first == 0) ? base1 : base0;
    if ((req & 1) != 0) applyStimulus(0, 1, 0, 0, '0, '0, '0);
    if ((req & 2) != 0) applyStimulus(1, 1, 0, 0, '0, '0, '0);
    toNeg();
    checkOutput("rnd_idle_before", 32'(gnt_o), 32'd0);
    tick(); toNeg();
    checkOutput("rnd_first_gnt", 32'(gnt_o), 32'(1 << first));
    tick();
    burst(first, nf, wf, bf);
    applyStimulus(first, 0, 0, 0, '0, '0, '0);
    toNeg();
    checkOutput("rnd_drop_gnt", 32'(gnt_o), 32'(1 << first));
    checkOutput("rnd_drop_stb", 32'(s_stb_o), 32'd0);
    lastOwner = first;
    if (second >= 0) begin
      tick(); toNeg();
      checkOutput("rnd_idle_gap", 32'(gnt_o), 32'd0);
      tick(); toNeg();
      checkOutput("rnd_second_gnt", 32'(gnt_o), 32'(1 << second));
      tick();
      burst(second, ns, ws, bs);
      applyStimulus(second, 0, 0, 0, '0, '0, '0);
      toNeg();
      lastOwner = second;
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    ackEnable = 1'b1;
    rst = 1'b1;
    doReset();
    checkOutput("reset_gnt", 32'(gnt_o), 32'd0);
    checkOutput("reset_cyc", 32'(s_cyc_o), 32'd0);

    // Single m0 read: grant one cycle after cyc, ack one cycle after that.
    applyStimulus(0, 1, 1, 0, 11'h10, '0, 4'hF);
    toNeg();
    checkOutput("t1_gnt_n", 32'(gnt_o), 32'd0);
    checkOutput("t1_stb_n", 32'(s_stb_o), 32'd0);
    tick(); toNeg();
    checkOutput("t1_gnt_n1", 32'(gnt_o), 32'd1);
    checkOutput("t1_stb_n1", 32'(s_stb_o), 32'd1);
    checkOutput("t1_adr_n1", 32'(s_adr_o), 32'h10);
    checkOutput("t1_ack_n1", 32'(m0_ack_o), 32'd0);
    tick(); toNeg();
    checkOutput("t1_ack_n2", 32'(m0_ack_o), 32'd1);
    checkOutput("t1_dat_n2", m0_dat_o, shadow[16]);
    checkOutput("t1_m1ack_n2", 32'(m1_ack_o), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
    lastOwner = 0;
    tick();

    // Tie after reset goes to m0, then m1, then m0 again.
    doReset();
    round(3, 2, 1, 0, 1, 8, 12);
    round(3, 1, 1, 0, 0, 12, 8);

    // Locked m1 write burst while m0 waits, then m0 reads it back.
    round(1, 1, 0, 0, 0, 4, 0);
    round(3, 4, 4, 0, 1, 11'h40, 11'h40);

    // Owner drops cyc in the same cycle as its ack.
    applyStimulus(0, 1, 1, 0, 11'h20, '0, 4'hF);
    tick(); toNeg();
    checkOutput("t6_gnt", 32'(gnt_o), 32'd1);
    applyStimulus(1, 1, 0, 0, '0, '0, '0);
    tick(); toNeg();
    checkOutput("t6_ack", 32'(m0_ack_o), 32'd1);
    #1;
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
    #1;
    checkOutput("t6_ack_after_drop", 32'(m0_ack_o), 32'd1);
    checkOutput("t6_m1_ack", 32'(m1_ack_o), 32'd0);
    tick(); toNeg();
    checkOutput("t6_idle", 32'(gnt_o), 32'd0);
    checkOutput("t6_idle_ack0", 32'(m0_ack_o), 32'd0);
    checkOutput("t6_idle_ack1", 32'(m1_ack_o), 32'd0);
    tick(); toNeg();
    checkOutput("t6_m1_gnt", 32'(gnt_o), 32'd2);
    tick();
    applyStimulus(1, 0, 0, 0, '0, '0, '0);
    lastOwner = 1;
    tick(); tick();

    // Watchdog: silent slave, error pulse on the 16th cycle after s_stb_o rises.
    ackEnable = 1'b0;
    applyStimulus(0, 1, 1, 0, 11'h30, '0, 4'hF);
    for (int k = 0; k <= 20; k++) begin
      tick(); toNeg();
      checkOutput($sformatf("t4_m0_err_k%0d", k), 32'(m0_err_o), 32'(k == TMO));
      checkOutput($sformatf("t4_m1_err_k%0d", k), 32'(m1_err_o), 32'd0);
      if (k == TMO) checkOutput("t4_gnt_kept", 32'(gnt_o), 32'd1);
    end
    tick();
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
    ackEnable = 1'b1;
    lastOwner = 0;
    tick(); tick();

    // Asynchronous reset between strobe and ack.
    applyStimulus(0, 1, 1, 0, 11'h18, '0, 4'hF);
    tick(); toNeg();
    checkOutput("t5_stb_before", 32'(s_stb_o), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t5_gnt", 32'(gnt_o), 32'd0);
    checkOutput("t5_stb", 32'(s_stb_o), 32'd0);
    checkOutput("t5_cyc", 32'(s_cyc_o), 32'd0);
    checkOutput("t5_ack", 32'(m0_ack_o), 32'd0);
    doReset();
    round(3, 1, 1, 0, 0, 3, 5);

    // Randomized rounds against the shadow memory and ownership model.
    for (int r = 0; r < 30; r++) begin
      round($urandom_range(1, 3), $urandom_range(1, 4), $urandom_range(1, 4),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 63), $urandom_range(0, 63));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
